// File: rtl/spike_pipe_pkg.sv
// Shared constants and parameter helpers for the spike raster pipe packer.
package spike_pipe_pkg;

    localparam int WORD_W = 16;

    // Number of raster ticks that fit in one packed word.
    function automatic int ticks_per_word(input int nch);
        return WORD_W / nch;
    endfunction

    // Channel counts that tile a 16-bit word exactly.
    function automatic bit nch_legal(input int nch);
        return (nch == 1) || (nch == 2) || (nch == 4) || (nch == 8);
    endfunction

    // A block must be non-empty and fit in the FIFO, whose depth must match AW.
    function automatic bit fifo_params_legal(input int depth, input int aw, input int block);
        return (depth == (1 << aw)) && (block >= 1) && (block <= depth);
    endfunction

endpackage

// File: rtl/pipe_fifo.sv
// Synchronous word FIFO with registered read data, drop-on-full writes,
// empty reads returning zero, sticky overflow/underflow and a registered
// occupancy threshold flag computed from the post-update count.
module pipe_fifo
    import spike_pipe_pkg::*;
#(
    parameter int DEPTH  = 1024,
    parameter int AW     = 10,
    parameter int THRESH = 256
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_en,
    input  logic [WORD_W-1:0] wr_data,
    input  logic              rd_en,
    output logic [WORD_W-1:0] rd_data,
    output logic [AW:0]       count,
    output logic              at_thresh,
    output logic              overflow,
    output logic              underflow
);

    logic [WORD_W-1:0] mem_q [DEPTH];
    logic [AW-1:0]     wptr_q, wptr_d;
    logic [AW-1:0]     rptr_q, rptr_d;
    logic [AW:0]       count_q, count_d;
    logic [WORD_W-1:0] rd_data_q, rd_data_d;
    logic              thr_q, thr_d;
    logic              ovf_q, ovf_d;
    logic              udf_q, udf_d;
    logic              full, empty, do_pop, do_push;

    assign full    = (count_q == (AW+1)'(DEPTH));
    assign empty   = (count_q == '0);
    assign do_pop  = rd_en && !empty;
    // A pop in the same cycle frees the slot, so a push at full still lands.
    assign do_push = wr_en && (!full || do_pop);

    // Next-state for pointers, occupancy, read data and flags.
    always_comb begin
        wptr_d    = wptr_q;
        rptr_d    = rptr_q;
        rd_data_d = rd_data_q;
        if (do_push) wptr_d = wptr_q + AW'(1);
        if (do_pop)  rptr_d = rptr_q + AW'(1);
        count_d = count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
        if (rd_en) rd_data_d = empty ? '0 : mem_q[rptr_q];
        thr_d = (count_d >= (AW+1)'(THRESH));
        ovf_d = ovf_q | (wr_en && !do_push);
        udf_d = udf_q | (rd_en && empty);
    end

    // Storage array; contents are don't-care until written, so no reset.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wptr_q] <= wr_data;
    end

    // Control state registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wptr_q    <= '0;
            rptr_q    <= '0;
            count_q   <= '0;
            rd_data_q <= '0;
            thr_q     <= 1'b0;
            ovf_q     <= 1'b0;
            udf_q     <= 1'b0;
        end else begin
            wptr_q    <= wptr_d;
            rptr_q    <= rptr_d;
            count_q   <= count_d;
            rd_data_q <= rd_data_d;
            thr_q     <= thr_d;
            ovf_q     <= ovf_d;
            udf_q     <= udf_d;
        end
    end

    assign rd_data   = rd_data_q;
    assign count     = count_q;
    assign at_thresh = thr_q;
    assign overflow  = ovf_q;
    assign underflow = udf_q;

endmodule

// File: rtl/spike_pipe_packer.sv
// Packs per-tick spike bits into 16-bit raster words (tick 0 in the LSBs)
// and buffers them for block readout over a pipe-out endpoint. The tick and
// spike levels are asynchronous and are synchronized here.
module spike_pipe_packer
    import spike_pipe_pkg::*;
#(
    parameter int NCH   = 2,
    parameter int DEPTH = 1024,
    parameter int AW    = 10,
    parameter int BLOCK = 256
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              tick,
    input  logic [NCH-1:0]    spike_in,
    input  logic              enable,
    input  logic              pipe_read,
    output logic [WORD_W-1:0] pipe_data,
    output logic              pipe_ready,
    output logic [AW:0]       word_count,
    output logic              overflow,
    output logic              underflow
);

    localparam int TPW = ticks_per_word(NCH);
    localparam int KW  = (TPW > 1) ? $clog2(TPW) : 1;
    // Bit 0 carries tick, bits NCH:1 carry the spike channels.
    localparam int SW  = NCH + 1;

    if (!(nch_legal(NCH) && fifo_params_legal(DEPTH, AW, BLOCK))) begin : g_bad_params
        $error("spike_pipe_packer: illegal NCH/DEPTH/AW/BLOCK combination");
    end

    logic [SW-1:0]     s1_q, s1_d, s2_q, s2_d, s3_q, s3_d;
    logic [SW-1:0]     edge_q, edge_d;
    logic [NCH-1:0]    latch_q, latch_d;
    logic [WORD_W-1:0] acc_q, acc_d;
    logic [KW-1:0]     k_q, k_d;
    logic              push_q, push_d;
    logic [WORD_W-1:0] push_word_q, push_word_d;
    logic              tick_pulse;
    logic [NCH-1:0]    spk_edge, captured;

    // Two-flop synchronizer, a history flop, and a registered rising-edge
    // strobe; tick and spikes share the path so their edges stay aligned.
    always_comb begin
        s1_d   = {spike_in, tick};
        s2_d   = s1_q;
        s3_d   = s2_q;
        edge_d = s2_q & ~s3_q;
    end

    assign tick_pulse = edge_q[0];
    assign spk_edge   = edge_q[SW-1:1];
    // A spike edge landing on the tick strobe belongs to the closing tick.
    assign captured   = latch_q | spk_edge;

    // Latch spikes within a tick and pack each closed tick into the word.
    always_comb begin
        latch_d     = latch_q | spk_edge;
        acc_d       = acc_q;
        k_d         = k_q;
        push_d      = 1'b0;
        push_word_d = push_word_q;
        if (!enable) begin
            // Idle and discard any partial word; next enable starts at tick 0.
            latch_d = '0;
            acc_d   = '0;
            k_d     = '0;
        end else if (tick_pulse) begin
            latch_d = '0;
            acc_d[int'(k_q)*NCH +: NCH] = captured;
            if (k_q == KW'(TPW - 1)) begin
                push_d      = 1'b1;
                push_word_d = acc_d;
                acc_d       = '0;
                k_d         = '0;
            end else begin
                k_d = k_q + KW'(1);
            end
        end
    end

    // Synchronizer, latch and packer registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_q        <= '0;
            s2_q        <= '0;
            s3_q        <= '0;
            edge_q      <= '0;
            latch_q     <= '0;
            acc_q       <= '0;
            k_q         <= '0;
            push_q      <= 1'b0;
            push_word_q <= '0;
        end else begin
            s1_q        <= s1_d;
            s2_q        <= s2_d;
            s3_q        <= s3_d;
            edge_q      <= edge_d;
            latch_q     <= latch_d;
            acc_q       <= acc_d;
            k_q         <= k_d;
            push_q      <= push_d;
            push_word_q <= push_word_d;
        end
    end

    pipe_fifo #(
        .DEPTH (DEPTH),
        .AW    (AW),
        .THRESH(BLOCK)
    ) u_fifo (
        .clk      (clk),
        .reset    (reset),
        .wr_en    (push_q),
        .wr_data  (push_word_q),
        .rd_en    (pipe_read),
        .rd_data  (pipe_data),
        .count    (word_count),
        .at_thresh(pipe_ready),
        .overflow (overflow),
        .underflow(underflow)
    );

endmodule

// File: tb/tb_spike_pipe_packer.sv
// Directed bench for spike_pipe_packer with a queue-based raster model.
module tb_spike_pipe_packer;

    localparam int NCH   = 2;
    localparam int DEPTH = 8;
    localparam int AW    = 3;
    localparam int BLOCK = 4;
    localparam int TPW   = 16 / NCH;

    logic           clk = 1'b0;
    logic           reset = 1'b1;
    logic           tick = 1'b0;
    logic [NCH-1:0] spike_in = '0;
    logic           enable = 1'b0;
    logic           pipe_read = 1'b0;
    logic [15:0]    pipe_data;
    logic           pipe_ready;
    logic [AW:0]    word_count;
    logic           overflow;
    logic           underflow;

    always #5 clk = ~clk;

    spike_pipe_packer #(.NCH(NCH), .DEPTH(DEPTH), .AW(AW), .BLOCK(BLOCK)) dut (
        .clk       (clk),
        .reset     (reset),
        .tick      (tick),
        .spike_in  (spike_in),
        .enable    (enable),
        .pipe_read (pipe_read),
        .pipe_data (pipe_data),
        .pipe_ready(pipe_ready),
        .word_count(word_count),
        .overflow  (overflow),
        .underflow (underflow)
    );

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_en = 1'b0;

    // Model: FIFO contents as a queue, the word under construction, flags.
    logic [15:0] mq[$];
    logic [15:0] m_acc;
    logic [15:0] m_data;
    int          m_k;
    bit          m_en, m_over, m_under;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void model_reset();
        mq.delete();
        m_acc   = '0;
        m_data  = '0;
        m_k     = 0;
        m_over  = 1'b0;
        m_under = 1'b0;
    endfunction

    function automatic void model_read();
        if (mq.size() == 0) begin
            m_data  = '0;
            m_under = 1'b1;
        end else begin
            m_data = mq.pop_front();
        end
    endfunction

    // One closed tick: the set of channels that spiked lands in slot m_k.
    function automatic void model_tick(input logic [NCH-1:0] spk, input bit rd);
        if (rd) model_read();
        if (m_en) begin
            m_acc[m_k*NCH +: NCH] = spk;
            m_k++;
            if (m_k == TPW) begin
                if (mq.size() < DEPTH) mq.push_back(m_acc);
                else m_over = 1'b1;
                m_acc = '0;
                m_k   = 0;
            end
        end
    endfunction

    // Every cycle outside the tick-latency window the DUT must match the model.
    always @(negedge clk) begin
        if (chk_en) begin
            check("word_count", 32'(word_count), 32'(mq.size()));
            check("pipe_ready", 32'(pipe_ready), 32'(mq.size() >= BLOCK));
            check("pipe_data",  32'(pipe_data),  32'(m_data));
            check("overflow",   32'(overflow),   32'(m_over));
            check("underflow",  32'(underflow),  32'(m_under));
        end
    end

    // 20-clk tick period. Non-coincident spikes pulse at c=1,4,7 (np of them);
    // coincident spikes rise together with tick at c=10. With rd set, a read
    // is issued in the exact cycle the completed word is written.
    task automatic run_tick(input logic [NCH-1:0] spk, input bit coinc, input int np, input bit rd);
        for (int c = 0; c < 20; c++) begin
            @(posedge clk); #1;
            for (int ch = 0; ch < NCH; ch++) begin
                if (coinc) spike_in[ch] = spk[ch] && (c >= 10) && (c < 12);
                else       spike_in[ch] = spk[ch] && (c < 3*np) && (c % 3 == 1);
            end
            tick      = (c >= 10) && (c < 15);
            pipe_read = rd && (c == 14);
            if (c == 10) chk_en = 1'b0;
            if (c == 18) begin
                model_tick(spk, rd);
                chk_en = 1'b1;
            end
        end
    endtask

    task automatic tk(input logic [NCH-1:0] spk);
        run_tick(spk, 1'b0, 1, 1'b0);
    endtask

    task automatic do_read();
        @(posedge clk); #1 pipe_read = 1'b1;
        @(posedge clk); #1 pipe_read = 1'b0;
        model_read();
    endtask

    task automatic set_enable(input bit v);
        @(posedge clk); #1 enable = v;
        m_en = v;
        if (!v) begin
            m_k   = 0;
            m_acc = '0;
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_data"},  32'(pipe_data),  32'h0);
        check({tag, "_ready"}, 32'(pipe_ready), 32'h0);
        check({tag, "_count"}, 32'(word_count), 32'h0);
        check({tag, "_ovf"},   32'(overflow),   32'h0);
        check({tag, "_udf"},   32'(underflow),  32'h0);
    endtask

    initial begin
        m_en = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_outputs("reset");
        @(posedge clk); #1 reset = 1'b0;
        set_enable(1'b1);
        chk_en = 1'b1;

        // Packing order: ch0 in ticks 0 and 3, ch1 in tick 7 -> 16'h8041.
        for (int t = 0; t < TPW; t++)
            tk((t == 0 || t == 3) ? 2'b01 : (t == 7) ? 2'b10 : 2'b00);
        check("pack_count", 32'(word_count), 32'd1);
        do_read();
        check("pack_word", 32'(pipe_data), 32'h8041);

        // Block readout: four all-ones words.
        repeat (4 * TPW) tk(2'b11);
        check("blk_ready", 32'(pipe_ready), 32'd1);
        check("blk_count", 32'(word_count), 32'd4);
        for (int i = 0; i < 4; i++) begin
            do_read();
            check("blk_word", 32'(pipe_data), 32'hFFFF);
        end
        check("blk_count_end", 32'(word_count), 32'd0);
        check("blk_ready_end", 32'(pipe_ready), 32'd0);

        // Coincident edges on tick 0, three spikes on ch1 in tick 1 -> 16'h000B.
        run_tick(2'b11, 1'b1, 1, 1'b0);
        run_tick(2'b10, 1'b0, 3, 1'b0);
        for (int t = 2; t < TPW; t++) tk(2'b00);
        do_read();
        check("coinc_word", 32'(pipe_data), 32'h000B);

        // Underflow on empty FIFO.
        do_read();
        check("udf_data",  32'(pipe_data),  32'h0);
        check("udf_flag",  32'(underflow),  32'd1);
        check("udf_count", 32'(word_count), 32'd0);

        // Overflow: ten zero words into an eight-deep FIFO.
        repeat (80) tk(2'b00);
        check("ovf_count", 32'(word_count), 32'd8);
        check("ovf_flag",  32'(overflow),   32'd1);
        do_read();
        check("ovf_oldest", 32'(pipe_data), 32'h0);
        // Refill with 16'h0005, then a 16'h0300 push coinciding with a pop at full.
        tk(2'b01); tk(2'b01);
        for (int t = 2; t < TPW; t++) tk(2'b00);
        check("refill_count", 32'(word_count), 32'd8);
        for (int t = 0; t < TPW - 1; t++) tk((t == 4) ? 2'b11 : 2'b00);
        run_tick(2'b00, 1'b0, 1, 1'b1);
        check("full_pushpop_count", 32'(word_count), 32'd8);
        for (int i = 0; i < 6; i++) do_read();
        do_read();
        check("drain_0005", 32'(pipe_data), 32'h0005);
        do_read();
        check("drain_0300", 32'(pipe_data), 32'h0300);

        // Enable drop after 5 ticks discards the partial word.
        repeat (5) tk(2'b11);
        set_enable(1'b0);
        repeat (3) tk(2'b11);
        set_enable(1'b1);
        tk(2'b01);
        for (int t = 1; t < TPW; t++) tk(2'b00);
        check("en_count", 32'(word_count), 32'd1);
        do_read();
        check("en_word", 32'(pipe_data), 32'h0001);

        // Asynchronous reset in the middle of a readout.
        repeat (4 * TPW) tk(2'b01);
        do_read();
        check("pre_rst_word", 32'(pipe_data), 32'h5555);
        do_read();
        @(posedge clk); #2 reset = 1'b1;
        model_reset();
        #1 check_reset_outputs("async_rst");
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_en = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
